// File: rtl/fft_seq_pkg.sv
// Shared constants and state encoding for the FFT frame sequencer.
package fft_seq_pkg;

    localparam int unsigned FFT_N         = 512;
    localparam int unsigned FFT_LOG2N     = 9;
    localparam int unsigned FFT_CNT_W     = 11;
    localparam logic [17:0] FFT_SCALE_SCH = 18'd18;
    localparam logic        FWD           = 1'b1;

    typedef enum logic [2:0] {
        CFG,
        IDLE,
        LOAD,
        CALC,
        UNLOAD,
        SWAP
    } state_t;

endpackage

// File: rtl/frame_load_counter.sv
// Issues exactly N FIFO read strobes, stalling while the FIFO is empty,
// then allows one data-settle cycle before pulsing done.
module frame_load_counter #(
    parameter int unsigned N     = 512,
    parameter int unsigned LOG2N = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic fifo_empty,
    output logic rd_en,
    output logic ce_next,
    output logic done
);

    localparam logic [LOG2N:0] N_CNT = (LOG2N+1)'(N);

    logic             active;
    logic [LOG2N:0]   cnt;
    logic [LOG2N:0]   issued;
    logic             rd_en_next;

    // issued includes the strobe currently on the bus, so the next strobe
    // decision is made against the count as it will be after this edge
    always_comb begin
        issued     = cnt + {{LOG2N{1'b0}}, rd_en};
        rd_en_next = 1'b0;
        ce_next    = 1'b0;
        if (start) begin
            rd_en_next = ~fifo_empty;
            ce_next    = rd_en_next;
        end else if (active) begin
            rd_en_next = (issued < N_CNT) && !fifo_empty;
            ce_next    = rd_en_next || (issued == N_CNT);
        end
    end

    assign done = active && (cnt == N_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            rd_en  <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            rd_en  <= rd_en_next;
        end else if (active) begin
            cnt   <= issued;
            rd_en <= rd_en_next;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: configures the FFT core, streams one frame from the FIFO,
// writes the spectrum into the hidden RAM bank and swaps display banks.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned N         = FFT_N,
    parameter int unsigned LOG2N     = FFT_LOG2N,
    parameter int unsigned CNT_W     = FFT_CNT_W,
    parameter logic [17:0] SCALE_SCH = FFT_SCALE_SCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             fft_ce,
    output logic             fft_start,
    output logic             fft_unload,
    output logic             fft_fwd_inv_we,
    output logic             fft_scale_sch_we,
    output logic             fft_fwd_inv,
    output logic [17:0]      fft_scale_sch,
    input  logic             fft_rfd,
    input  logic             fft_done,
    input  logic             fft_dv,
    input  logic [LOG2N-1:0] fft_xk_index,
    output logic             ram_we,
    output logic [LOG2N:0]   ram_waddr,
    output logic             disp_bank,
    input  logic             freeze,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
    localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N - 1);

    state_t state, state_next;

    logic cfg_we;
    logic cfg_we_n, start_n, unload_n, ce_n, frame_done_n;
    logic load_start, load_ce_next, load_done;

    // Reads only begin once a full frame is buffered, so rfd is not needed
    logic unused_rfd;
    assign unused_rfd = fft_rfd;

    assign fft_fwd_inv      = FWD;
    assign fft_scale_sch    = SCALE_SCH;
    assign fft_fwd_inv_we   = cfg_we;
    assign fft_scale_sch_we = cfg_we;

    // Unregistered so the RAM write lines up with the core's output beat
    assign ram_we    = (state == UNLOAD) && fft_dv;
    assign ram_waddr = {~disp_bank, fft_xk_index};

    frame_load_counter #(
        .N     (N),
        .LOG2N (LOG2N)
    ) u_load_cnt (
        .clk        (clk),
        .rst        (rst),
        .start      (load_start),
        .fifo_empty (fifo_empty),
        .rd_en      (fifo_rd_en),
        .ce_next    (load_ce_next),
        .done       (load_done)
    );

    always_comb begin
        state_next   = state;
        cfg_we_n     = 1'b0;
        start_n      = 1'b0;
        unload_n     = 1'b0;
        ce_n         = 1'b0;
        frame_done_n = 1'b0;
        load_start   = 1'b0;
        case (state)
            CFG: begin
                state_next = IDLE;
                cfg_we_n   = 1'b1;
            end
            IDLE: begin
                if (fifo_count >= N_CNT) begin
                    state_next = LOAD;
                    load_start = 1'b1;
                    start_n    = 1'b1;
                    ce_n       = load_ce_next;
                end
            end
            LOAD: begin
                if (load_done) begin
                    state_next = CALC;
                    ce_n       = 1'b1;
                end else begin
                    ce_n = load_ce_next;
                end
            end
            CALC: begin
                ce_n = 1'b1;
                if (fft_done) begin
                    state_next = UNLOAD;
                    unload_n   = 1'b1;
                end
            end
            UNLOAD: begin
                if (fft_dv && (fft_xk_index == LAST_BIN)) begin
                    state_next   = SWAP;
                    frame_done_n = 1'b1;
                end else begin
                    ce_n = 1'b1;
                end
            end
            SWAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = CFG;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CFG;
            cfg_we     <= 1'b0;
            fft_start  <= 1'b0;
            fft_unload <= 1'b0;
            fft_ce     <= 1'b0;
            frame_done <= 1'b0;
            disp_bank  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            cfg_we     <= cfg_we_n;
            fft_start  <= start_n;
            fft_unload <= unload_n;
            fft_ce     <= ce_n;
            frame_done <= frame_done_n;
            if ((state == SWAP) && !freeze) begin
                disp_bank <= ~disp_bank;
            end
            if ((state != IDLE) && (fifo_count == '1)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
